// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: writeback bus between the ALU/load requesters, the
// arbiter and the register-file write port. The arbiter uses the slave
// modport; whoever drives the requests and observes the write port uses
// the master modport.
interface regfile_wb_arbiter_if;
    logic        alu_req;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_gnt;
    logic        mem_req;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        mem_gnt;
    logic        hold;
    logic        W;
    logic [4:0]  RD;
    logic [31:0] Data_In;
    logic        pending;
    logic [15:0] wr_count;

    modport slave (
        input  alu_req, alu_rd, alu_data,
        input  mem_req, mem_rd, mem_data,
        input  hold,
        output alu_gnt, mem_gnt,
        output W, RD, Data_In, pending, wr_count
    );

    modport master (
        output alu_req, alu_rd, alu_data,
        output mem_req, mem_rd, mem_data,
        output hold,
        input  alu_gnt, mem_gnt,
        input  W, RD, Data_In, pending, wr_count
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin arbitration of ALU and load writebacks into
// a single pending slot that drives the register-file write port.
// The slot drains and refills in the same cycle, so back-to-back requests
// give one write per cycle. hold freezes grants and the write port.
// Optional build macro: WB_RD0_FILTER_EN -- when defined, requests for x0
// are granted (and update round-robin priority) but never fill the slot,
// so they never produce a register-file write.
module regfile_wb_arbiter (
    input  logic                 clock,
    input  logic                 reset,
    regfile_wb_arbiter_if.slave  bus
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;
    typedef enum logic {GNT_ALU = 1'b0, GNT_MEM = 1'b1} gnt_t;

    state_t      state_q;
    state_t      state_d;
    gnt_t        last_gnt_q;
    gnt_t        last_gnt_d;
    logic [4:0]  slot_rd_q;
    logic [31:0] slot_data_q;
    logic [15:0] wr_count_q;

    logic        w;
    logic        can_accept;
    logic        alu_gnt;
    logic        mem_gnt;
    logic        grant;
    logic        fill;
    logic [4:0]  gnt_rd;
    logic [31:0] gnt_data;

    // Arbitration, write enable and next-state decode.
    always_comb begin
        // NOTE: every variable written here gets a value before any branch, so no path leaves one unassigned and infers a latch.
        state_d    = state_q;
        last_gnt_d = last_gnt_q;

        w          = (state_q == FULL) && !bus.hold;
        // The slot takes a new entry if it is empty or is being written out now.
        can_accept = !bus.hold && ((state_q == EMPTY) || w);

        // On a tie the requester that did not win last time goes first.
        alu_gnt    = can_accept && bus.alu_req &&
                     (!bus.mem_req || (last_gnt_q == GNT_MEM));
        mem_gnt    = can_accept && bus.mem_req && !alu_gnt;
        grant      = alu_gnt || mem_gnt;

        gnt_rd     = alu_gnt ? bus.alu_rd   : bus.mem_rd;
        gnt_data   = alu_gnt ? bus.alu_data : bus.mem_data;

`ifdef WB_RD0_FILTER_EN
        // Writes to x0 are accepted from the requester but dropped here.
        fill       = grant && (gnt_rd != 5'd0);
`else
        fill       = grant;
`endif

        if (grant) begin
            last_gnt_d = alu_gnt ? GNT_ALU : GNT_MEM;
        end

        if (fill) begin
            state_d = FULL;
        end else if (w) begin
            state_d = EMPTY;
        end
    end

    // State and round-robin priority registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // NOTE: sequential state is always updated with non-blocking assignments so every flop samples pre-edge values.
            state_q    <= EMPTY;
            last_gnt_q <= GNT_MEM;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
        end
    end

    // Slot contents: loaded from the winning requester, otherwise held.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // NOTE: the slot data registers are reset because they drive RD/Data_In directly and must read zero during reset.
            slot_rd_q   <= '0;
            slot_data_q <= '0;
        end else if (fill) begin
            slot_rd_q   <= gnt_rd;
            slot_data_q <= gnt_data;
        end
    end

    // Committed-write counter; wraps naturally at 16 bits.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_count_q <= '0;
        end else if (w) begin
            wr_count_q <= wr_count_q + 16'd1;
        end
    end

    // Grants are combinational from the requests, so they are masked during
    // reset; the internal grant path stays free of the reset net.
    assign bus.alu_gnt  = alu_gnt && reset;
    assign bus.mem_gnt  = mem_gnt && reset;
    assign bus.W        = w;
    assign bus.RD       = slot_rd_q;
    assign bus.Data_In  = slot_data_q;
    assign bus.pending  = (state_q == FULL);
    assign bus.wr_count = wr_count_q;
endmodule
